// File: rtl/nlprg_scheduler.sv
// nlprg_scheduler: shares one 16-bit NLPRG state among NREQ requesters with round-robin
// bursts, seed load and post-seed warm-up discard.
module nlprg_scheduler #(
   parameter int NREQ   = 4,
   parameter int BURST  = 4,
   parameter int WARMUP = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            seed_load,
   input  logic [15:0]     seed,
   input  logic [NREQ-1:0] req,
   input  logic            ack,
   output logic [NREQ-1:0] gnt,
   output logic [15:0]     rnd,
   output logic            rnd_valid,
   output logic            busy
);
   localparam int IW = $clog2(NREQ);
   typedef enum logic [1:0] {WARM, ARB, SERVE} fsm_t;
   fsm_t            fsm;
   logic [15:0]     q;
   logic [7:0]      wcnt, bcnt;
   logic [IW-1:0]   rr_ptr, cur, pick, nxt;
   logic            any, rel;
   function automatic logic [15:0] step(input logic [15:0] s);
      logic z;
      z = (s[15:5] == 11'd0) && (s[3:0] == 4'hF);
      step = {s[14:5], ~(s[7] ^ s[4]) ^ z, s[6] ^ s[7] ^ s[3], s[8] ^ s[9] ^ s[2],
              s[10] ^ s[11] ^ s[1], s[12] ^ s[13] ^ s[0], ~(s[14] ^ s[15] ^ s[5])};
   endfunction
   // Scan downward so the requester closest to rr_ptr is the last (winning) assignment
   always_comb begin
      pick = '0;
      any  = 1'b0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (req[IW'((int'(rr_ptr) + k) % NREQ)]) begin
            pick = IW'((int'(rr_ptr) + k) % NREQ);
            any  = 1'b1;
         end
      end
   end
   assign nxt = (cur == IW'(NREQ - 1)) ? '0 : cur + IW'(1);
   assign rel = (ack && (bcnt + 8'd1 == 8'(BURST))) || !req[cur];
   assign rnd = q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q         <= 16'h0000;
         gnt       <= '0;
         rnd_valid <= 1'b0;
         busy      <= 1'b1;
         rr_ptr    <= '0;
         cur       <= '0;
         wcnt      <= 8'd0;
         bcnt      <= 8'd0;
         fsm       <= WARM;
      end else if (seed_load) begin
         q         <= seed;
         gnt       <= '0;
         rnd_valid <= 1'b0;
         busy      <= 1'b1;
         wcnt      <= 8'd0;
         fsm       <= WARM;
      end else begin
         case (fsm)
            WARM: begin
               if (WARMUP == 0) begin
                  fsm  <= ARB;
                  busy <= 1'b0;
               end else begin
                  q    <= step(q);
                  wcnt <= wcnt + 8'd1;
                  if (wcnt == 8'(WARMUP - 1)) begin
                     fsm  <= ARB;
                     busy <= 1'b0;
                  end
               end
            end
            ARB: begin
               if (any) begin
                  gnt       <= NREQ'(1) << pick;
                  cur       <= pick;
                  bcnt      <= 8'd0;
                  rnd_valid <= 1'b1;
                  fsm       <= SERVE;
               end
            end
            SERVE: begin
               if (ack) begin
                  q    <= step(q);
                  bcnt <= bcnt + 8'd1;
               end
               if (rel) begin
                  gnt       <= '0;
                  rnd_valid <= 1'b0;
                  rr_ptr    <= nxt;
                  fsm       <= ARB;
               end
            end
            default: fsm <= ARB;
         endcase
      end
   end
endmodule

// File: tb/tb_nlprg_scheduler.sv
// tb_nlprg_scheduler: directed checks of the NLPRG scheduler across WARMUP=2, 0 and 16 variants
// sharing one stimulus, plus a randomised req/ack run checked against a word-sequence model.
module tb_nlprg_scheduler;
   logic        clk = 1'b0, rst_n = 1'b0, seed_load = 1'b0, ack = 1'b0;
   logic [15:0] seed = 16'h0000;
   logic [3:0]  req = 4'b0000;
   logic [3:0]  g2, g0, g16;
   logic [15:0] r2, r0, r16;
   logic        v2, v0, v16, b2, b0, b16;
   int          checks = 0, failures = 0;
   logic [15:0] m;
   logic        pv, pa;

   nlprg_scheduler #(.NREQ(4), .BURST(4), .WARMUP(2)) u2 (
      .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed(seed), .req(req), .ack(ack),
      .gnt(g2), .rnd(r2), .rnd_valid(v2), .busy(b2));
   nlprg_scheduler #(.NREQ(4), .BURST(4), .WARMUP(0)) u0 (
      .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed(seed), .req(req), .ack(ack),
      .gnt(g0), .rnd(r0), .rnd_valid(v0), .busy(b0));
   nlprg_scheduler #(.NREQ(4), .BURST(4), .WARMUP(16)) u16 (
      .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed(seed), .req(req), .ack(ack),
      .gnt(g16), .rnd(r16), .rnd_valid(v16), .busy(b16));

   always #5 clk = ~clk;

   function automatic logic [15:0] step(input logic [15:0] s);
      logic z;
      z = (s[15:5] == 11'd0) && (s[3:0] == 4'hF);
      step = {s[14:5], ~(s[7] ^ s[4]) ^ z, s[6] ^ s[7] ^ s[3], s[8] ^ s[9] ^ s[2],
              s[10] ^ s[11] ^ s[1], s[12] ^ s[13] ^ s[0], ~(s[14] ^ s[15] ^ s[5])};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      tick;
      tick;
      chk("rst_gnt", 32'(g16), 0);
      chk("rst_valid", 32'(v16), 0);
      chk("rst_rnd", 32'(r16), 0);
      chk("rst_busy", 32'(b16), 1);
      chk("rst_gnt2", 32'(g2), 0);
      rst_n = 1'b1;
      // warm-up of two steps from seed 0, then a grant to requester 0
      seed = 16'h0000; seed_load = 1'b1; req = 4'b0001; ack = 1'b1;
      tick;
      seed_load = 1'b0;
      chk("t1_seed", 32'(r2), 32'h0000);
      chk("t1_busy0", 32'(b2), 1);
      tick;
      chk("t1_w1", 32'(r2), 32'h0021);
      chk("t1_busy1", 32'(b2), 1);
      tick;
      chk("t1_w2", 32'(r2), 32'h0062);
      chk("t1_busy2", 32'(b2), 0);
      chk("t1_arb_gnt", 32'(g2), 0);
      chk("t1_arb_valid", 32'(v2), 0);
      tick;
      chk("t1_gnt", 32'(g2), 32'b0001);
      chk("t1_valid", 32'(v2), 1);
      chk("t1_word0", 32'(r2), 32'h0062);
      tick;
      chk("t1_word1", 32'(r2), 32'h00F4);
      chk("t1_gnt_hold", 32'(g2), 32'b0001);
      ack = 1'b0; req = 4'b0000;
      tick;
      chk("t1_rel_gnt", 32'(g2), 0);
      chk("t1_rel_rnd", 32'(r2), 32'h00F4);
      // all requesting, ack always: rr_ptr is 1 after the release above
      m = 16'h00F4; req = 4'b1111; ack = 1'b1;
      for (int g = 0; g < 5; g++) begin
         tick;
         chk("t2_gnt", 32'(g2), 32'(4'b0001 << ((1 + g) % 4)));
         chk("t2_valid", 32'(v2), 1);
         for (int w = 0; w < 4; w++) begin
            chk("t2_word", 32'(r2), 32'(m));
            m = step(m);
            tick;
         end
         chk("t2_idle_gnt", 32'(g2), 0);
         chk("t2_idle_valid", 32'(v2), 0);
         chk("t2_idle_rnd", 32'(r2), 32'(m));
      end
      // requester 2 drops after two words; next grant goes to 3
      req = 4'b1100;
      tick;
      chk("t3_gnt2", 32'(g2), 32'b0100);
      chk("t3_word0", 32'(r2), 32'(m));
      m = step(m);
      tick;
      chk("t3_word1", 32'(r2), 32'(m));
      m = step(m);
      tick;
      req = 4'b1000; ack = 1'b0;
      tick;
      chk("t3_rel_gnt", 32'(g2), 0);
      chk("t3_rel_rnd", 32'(r2), 32'(m));
      tick;
      chk("t3_gnt3", 32'(g2), 32'b1000);
      // seed load mid-burst with a simultaneous ack
      ack = 1'b1;
      chk("t4_word0", 32'(r2), 32'(m));
      m = step(m);
      tick;
      chk("t4_word1", 32'(r2), 32'(m));
      seed = 16'hBEEF; seed_load = 1'b1;
      tick;
      seed_load = 1'b0; ack = 1'b0; req = 4'b1111;
      chk("t4_seed", 32'(r2), 32'hBEEF);
      chk("t4_gnt", 32'(g2), 0);
      chk("t4_valid", 32'(v2), 0);
      chk("t4_busy", 32'(b2), 1);
      m = 16'hBEEF;
      tick;
      m = step(m);
      chk("t4_w1", 32'(r2), 32'(m));
      chk("t4_busy1", 32'(b2), 1);
      tick;
      m = step(m);
      chk("t4_w2", 32'(r2), 32'(m));
      chk("t4_busy2", 32'(b2), 0);
      chk("t4_arb_gnt", 32'(g2), 0);
      tick;
      chk("t4_regrant", 32'(g2), 32'b1000);
      chk("t4_first", 32'(r2), 32'(m));
      req = 4'b0000;
      tick;
      // Z corner with no warm-up
      seed = 16'h000F; seed_load = 1'b1;
      tick;
      seed_load = 1'b0; req = 4'b0001;
      chk("t5_seed", 32'(r0), 32'h000F);
      chk("t5_busy", 32'(b0), 1);
      tick;
      chk("t5_nowarm_busy", 32'(b0), 0);
      chk("t5_nowarm_rnd", 32'(r0), 32'h000F);
      chk("t5_arb_valid", 32'(v0), 0);
      tick;
      chk("t5_gnt", 32'(g0), 32'b0001);
      chk("t5_first", 32'(r0), 32'h000F);
      ack = 1'b1;
      tick;
      chk("t5_zstep", 32'(r0), 32'h001F);
      ack = 1'b0; req = 4'b0000;
      tick;
      chk("t5_rel_valid", 32'(v0), 0);
      chk("t5_rel_gnt", 32'(g0), 0);
      // WARMUP=16 instance: reach a burst then reset asynchronously
      seed = 16'h1234; seed_load = 1'b1;
      tick;
      seed_load = 1'b0; req = 4'b0001;
      m = 16'h1234;
      for (int i = 0; i < 16; i++) begin
         tick;
         m = step(m);
         chk("t6_busy_a", 32'(b16), 32'(i < 15));
      end
      chk("t6_warm_rnd", 32'(r16), 32'(m));
      tick;
      chk("t6_gnt", 32'(g16), 32'b0001);
      ack = 1'b1;
      tick;
      m = step(m);
      chk("t6_word1", 32'(r16), 32'(m));
      #2 rst_n = 1'b0;
      #1;
      chk("t6_async_gnt", 32'(g16), 0);
      chk("t6_async_valid", 32'(v16), 0);
      chk("t6_async_rnd", 32'(r16), 0);
      chk("t6_async_busy", 32'(b16), 1);
      tick;
      rst_n = 1'b1; req = 4'b0000; ack = 1'b0;
      m = 16'h0000;
      for (int i = 0; i < 16; i++) begin
         tick;
         m = step(m);
         chk("t6_busy_b", 32'(b16), 32'(i < 15));
      end
      chk("t6_warm2_rnd", 32'(r16), 32'(m));
      for (int c = 0; c < 200; c++) begin
         req = 4'($urandom);
         ack = 1'($urandom);
         pv = v16;
         pa = ack;
         tick;
         if (pv && pa) m = step(m);
         chk("rand_rnd", 32'(r16), 32'(m));
         chk("rand_onehot", 32'($onehot0(g16)), 1);
         chk("rand_gnt_valid", 32'(g16 != 4'b0000), 32'(v16));
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
